associative_buffer: RTL and testbench

- Small fully-associative key/data store of BUFFER_SIZE entries.
- Supports keyed load, increment and clear, plus continuous registered key lookup.
- A start_reading pulse runs a timed sequential dump of every slot, paced by an internal interval timer.
- Used as a generic lookup/cache element; single clock domain.

---
 rtl/associative_buffer_pkg.sv | 14 +
 rtl/associative_buffer_match_unit.sv | 39 +++
 rtl/associative_buffer.sv | 184 ++++++++++++++++++
 tb/tb_associative_buffer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/associative_buffer_pkg.sv
// Shared encodings for the associative buffer: command codes and the operating mode.
package associative_buffer_pkg;

    localparam logic [1:0] CTRL_NONE = 2'd0;
    localparam logic [1:0] CTRL_LOAD = 2'd1;
    localparam logic [1:0] CTRL_INCR = 2'd2;
    localparam logic [1:0] CTRL_CLR  = 2'd3;

    typedef enum logic {
        LOOKUP = 1'b0,
        DUMP   = 1'b1
    } mode_t;

endpackage

// File: rtl/associative_buffer_match_unit.sv
// Combinational key compare for the associative buffer: hit vector, lowest hit index
// and lowest free slot index.
module assoc_match_unit #(
    parameter int KEY_WIDTH   = 4,
    parameter int BUFFER_SIZE = 4
) (
    input  logic [BUFFER_SIZE-1:0]                i_valid,
    input  logic [BUFFER_SIZE-1:0][KEY_WIDTH-1:0] i_keys,
    input  logic [KEY_WIDTH-1:0]                  i_key,
    output logic [BUFFER_SIZE-1:0]                o_hitVec,
    output logic [$clog2(BUFFER_SIZE)-1:0]        o_hitIdx,
    output logic                                  o_free,
    output logic [$clog2(BUFFER_SIZE)-1:0]        o_freeIdx
);

    localparam int IW = $clog2(BUFFER_SIZE);

    // Scanning from the top down lets the lowest matching/free index win.
    always_comb begin
        logic w_match;
        o_hitVec  = '0;
        o_hitIdx  = '0;
        o_free    = 1'b0;
        o_freeIdx = '0;
        w_match   = 1'b0;
        for (int i = BUFFER_SIZE - 1; i >= 0; i--) begin
            w_match     = i_valid[i] && (i_keys[i] == i_key);
            o_hitVec[i] = w_match;
            if (w_match) begin
                o_hitIdx = IW'(i);
            end
            if (!i_valid[i]) begin
                o_free    = 1'b1;
                o_freeIdx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/associative_buffer.sv
// Fully-associative key/data store with registered lookup and a timed slot dump.
// Optional macro ASSOCIATIVE_BUFFER_INCR_SAT_EN makes INCR saturate instead of wrap.
module associative_buffer
    import associative_buffer_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int KEY_WIDTH      = 4,
    parameter int BUFFER_SIZE    = 4,
    parameter int TIMER_INTERVAL = 4
) (
    input  logic                  clk,
    input  logic                  async_reset,
    input  logic                  start_reading,
    input  logic [1:0]            ctrl,
    input  logic [KEY_WIDTH-1:0]  key,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid
);

    localparam int IW = $clog2(BUFFER_SIZE);
    localparam int TW = (TIMER_INTERVAL > 1) ? $clog2(TIMER_INTERVAL) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(BUFFER_SIZE - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(TIMER_INTERVAL - 1);

    typedef struct packed {
        logic                  valid;
        logic [KEY_WIDTH-1:0]  key;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t                               r_entries [BUFFER_SIZE];
    logic [IW-1:0]                        r_ptr;
    logic [IW-1:0]                        r_slotIdx;
    logic [TW-1:0]                        r_timer;
    mode_t                                r_mode;
    mode_t                                w_nextMode;
    logic [DATA_WIDTH-1:0]                r_dataOut;
    logic                                 r_valid;
    logic [DATA_WIDTH-1:0]                w_nextDataOut;
    logic                                 w_nextValid;
    logic [BUFFER_SIZE-1:0]               w_validVec;
    logic [BUFFER_SIZE-1:0][KEY_WIDTH-1:0] w_keys;
    logic [BUFFER_SIZE-1:0]               w_hitVec;
    logic [IW-1:0]                        w_hitIdx;
    logic [IW-1:0]                        w_freeIdx;
    logic                                 w_free;
    logic                                 w_hit;
    logic                                 w_lastTick;
    logic [DATA_WIDTH-1:0]                w_hitData;
    logic [DATA_WIDTH-1:0]                w_incrData;

    always_comb begin
        w_validVec = '0;
        w_keys     = '0;
        for (int i = 0; i < BUFFER_SIZE; i++) begin
            w_validVec[i] = r_entries[i].valid;
            w_keys[i]     = r_entries[i].key;
        end
    end

    assoc_match_unit #(
        .KEY_WIDTH   (KEY_WIDTH),
        .BUFFER_SIZE (BUFFER_SIZE)
    ) u_match (
        .i_valid   (w_validVec),
        .i_keys    (w_keys),
        .i_key     (key),
        .o_hitVec  (w_hitVec),
        .o_hitIdx  (w_hitIdx),
        .o_free    (w_free),
        .o_freeIdx (w_freeIdx)
    );

    assign w_hit      = |w_hitVec;
    assign w_hitData  = r_entries[w_hitIdx].data;
    assign w_lastTick = (r_timer == LAST_TICK);

`ifdef ASSOCIATIVE_BUFFER_INCR_SAT_EN
    assign w_incrData = (&w_hitData) ? w_hitData : w_hitData + DATA_WIDTH'(1);
`else
    assign w_incrData = w_hitData + DATA_WIDTH'(1);
`endif

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_mode <= LOOKUP;
        end else begin
            r_mode <= w_nextMode;
        end
    end

    always_comb begin
        w_nextMode = r_mode;
        case (r_mode)
            LOOKUP:  if (start_reading) w_nextMode = DUMP;
            DUMP:    if (w_lastTick && (r_slotIdx == LAST_IDX)) w_nextMode = LOOKUP;
            default: w_nextMode = LOOKUP;
        endcase
    end

    // Dumped slots are read from pre-edge contents, same as a lookup.
    always_comb begin
        w_nextDataOut = '0;
        w_nextValid   = 1'b0;
        case (r_mode)
            LOOKUP: begin
                if (w_hit) begin
                    w_nextDataOut = w_hitData;
                    w_nextValid   = 1'b1;
                end
            end
            DUMP: begin
                w_nextDataOut = r_entries[r_slotIdx].data;
                w_nextValid   = r_entries[r_slotIdx].valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_dataOut <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_dataOut <= w_nextDataOut;
            r_valid   <= w_nextValid;
        end
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_slotIdx <= '0;
            r_timer   <= '0;
        end else if (r_mode != DUMP) begin
            r_slotIdx <= '0;
            r_timer   <= '0;
        end else if (w_lastTick) begin
            r_timer   <= '0;
            r_slotIdx <= (r_slotIdx == LAST_IDX) ? '0 : r_slotIdx + IW'(1);
        end else begin
            r_timer   <= r_timer + TW'(1);
        end
    end

    // The replacement pointer only advances when a LOAD evicts an entry.
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            for (int i = 0; i < BUFFER_SIZE; i++) begin
                r_entries[i] <= '0;
            end
            r_ptr <= '0;
        end else begin
            case (ctrl)
                CTRL_LOAD: begin
                    if (w_hit) begin
                        r_entries[w_hitIdx].data <= data_in;
                    end else if (w_free) begin
                        r_entries[w_freeIdx] <= '{valid: 1'b1, key: key, data: data_in};
                    end else begin
                        r_entries[r_ptr] <= '{valid: 1'b1, key: key, data: data_in};
                        r_ptr <= (r_ptr == LAST_IDX) ? '0 : r_ptr + IW'(1);
                    end
                end
                CTRL_INCR: begin
                    if (w_hit) begin
                        r_entries[w_hitIdx].data <= w_incrData;
                    end
                end
                CTRL_CLR: begin
                    if (w_hit) begin
                        r_entries[w_hitIdx].valid <= 1'b0;
                        r_entries[w_hitIdx].data  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data_out = r_dataOut;
    assign valid    = r_valid;

endmodule

// File: tb/tb_associative_buffer.sv
// Self-checking bench for associative_buffer: a reference model of the store and dump
// sequence is checked every cycle, plus hand-computed expectations at key points.
module tb_associative_buffer;
    import associative_buffer_pkg::*;

    localparam int DW = 8;
    localparam int KW = 4;
    localparam int BS = 4;
    localparam int TI = 4;

`ifdef ASSOCIATIVE_BUFFER_INCR_SAT_EN
    localparam logic [DW-1:0] INCR_FF_EXP = 8'hFF;
`else
    localparam logic [DW-1:0] INCR_FF_EXP = 8'h00;
`endif

    logic          clk = 1'b0;
    logic          async_reset;
    logic          start_reading;
    logic [1:0]    ctrl;
    logic [KW-1:0] key;
    logic [DW-1:0] data_in;
    logic [DW-1:0] data_out;
    logic          valid;

    int checks = 0;
    int errors = 0;

    logic          mValid [BS];
    logic [KW-1:0] mKey   [BS];
    logic [DW-1:0] mData  [BS];
    int            mPtr;
    bit            mDumping;
    int            mDumpCount;
    logic [DW-1:0] expData;
    logic          expValid;
    bit            compareEn = 1'b0;

    always #5 clk = ~clk;

    associative_buffer #(
        .DATA_WIDTH     (DW),
        .KEY_WIDTH      (KW),
        .BUFFER_SIZE    (BS),
        .TIMER_INTERVAL (TI)
    ) dut (
        .clk           (clk),
        .async_reset   (async_reset),
        .start_reading (start_reading),
        .ctrl          (ctrl),
        .key           (key),
        .data_in       (data_in),
        .data_out      (data_out),
        .valid         (valid)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int modelFind(input logic [KW-1:0] k);
        for (int i = 0; i < BS; i++) begin
            if (mValid[i] && mKey[i] == k) return i;
        end
        return -1;
    endfunction

    function automatic int modelFree();
        for (int i = 0; i < BS; i++) begin
            if (!mValid[i]) return i;
        end
        return -1;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < BS; i++) begin
            mValid[i] = 1'b0;
            mKey[i]   = '0;
            mData[i]  = '0;
        end
        mPtr       = 0;
        mDumping   = 1'b0;
        mDumpCount = 0;
        expData    = '0;
        expValid   = 1'b0;
    endtask

    // Outputs at an edge reflect the store as it was before that edge's command.
    task automatic modelEdge(input bit st, input logic [1:0] c, input logic [KW-1:0] k,
                             input logic [DW-1:0] d);
        int h;
        int f;
        int slot;
        h = modelFind(k);
        if (mDumping) begin
            slot     = mDumpCount / TI;
            expData  = mData[slot];
            expValid = mValid[slot];
            mDumpCount++;
            if (mDumpCount == BS * TI) mDumping = 1'b0;
        end else begin
            expData  = (h >= 0) ? mData[h] : '0;
            expValid = (h >= 0);
            if (st) begin
                mDumping   = 1'b1;
                mDumpCount = 0;
            end
        end
        case (c)
            CTRL_LOAD: begin
                if (h >= 0) begin
                    mData[h] = d;
                end else begin
                    f = modelFree();
                    if (f < 0) begin
                        f    = mPtr;
                        mPtr = (mPtr + 1) % BS;
                    end
                    mValid[f] = 1'b1;
                    mKey[f]   = k;
                    mData[f]  = d;
                end
            end
            CTRL_INCR: begin
                if (h >= 0) begin
`ifdef ASSOCIATIVE_BUFFER_INCR_SAT_EN
                    if (mData[h] != 8'hFF) mData[h] = mData[h] + 8'd1;
`else
                    mData[h] = mData[h] + 8'd1;
`endif
                end
            end
            CTRL_CLR: begin
                if (h >= 0) begin
                    mValid[h] = 1'b0;
                    mData[h]  = '0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic applyStimulus(input bit st, input logic [1:0] c, input logic [KW-1:0] k,
                                 input logic [DW-1:0] d);
        start_reading = st;
        ctrl          = c;
        key           = k;
        data_in       = d;
        @(posedge clk);
        modelEdge(st, c, k, d);
        #1;
    endtask

    always @(negedge clk) begin
        if (compareEn && !async_reset) begin
            checkOutput("cycle_data_out", data_out, expData);
            checkOutput("cycle_valid", valid, expValid);
        end
    end

    initial begin
        bit            st;
        logic [1:0]    cmd;
        logic [KW-1:0] k;

        async_reset   = 1'b1;
        start_reading = 1'b0;
        ctrl          = CTRL_NONE;
        key           = '0;
        data_in       = '0;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_valid", valid, 1'b0);
        checkOutput("reset_data_out", data_out, 8'h00);
        async_reset = 1'b0;
        compareEn   = 1'b1;

        applyStimulus(0, CTRL_NONE, 4'd0, 8'h00);
        checkOutput("empty_key0_valid", valid, 1'b0);

        applyStimulus(0, CTRL_LOAD, 4'd0, 8'h00);
        applyStimulus(0, CTRL_NONE, 4'd0, 8'h00);
        applyStimulus(0, CTRL_LOAD, 4'd1, 8'h0F);
        applyStimulus(0, CTRL_NONE, 4'd1, 8'h00);
        applyStimulus(0, CTRL_LOAD, 4'd2, 8'hF0);
        applyStimulus(0, CTRL_NONE, 4'd2, 8'h00);
        applyStimulus(0, CTRL_LOAD, 4'd3, 8'hFF);
        applyStimulus(0, CTRL_NONE, 4'd3, 8'h00);
        applyStimulus(0, CTRL_NONE, 4'd2, 8'h00);
        checkOutput("key2_data", data_out, 8'hF0);
        checkOutput("key2_valid", valid, 1'b1);

        applyStimulus(0, CTRL_LOAD, 4'd8, 8'hDB);
        applyStimulus(0, CTRL_NONE, 4'd8, 8'h00);
        checkOutput("key8_data", data_out, 8'hDB);
        checkOutput("key8_valid", valid, 1'b1);
        applyStimulus(0, CTRL_NONE, 4'd0, 8'h00);
        checkOutput("evicted_key0_valid", valid, 1'b0);

        applyStimulus(0, CTRL_INCR, 4'd3, 8'h00);
        applyStimulus(0, CTRL_NONE, 4'd3, 8'h00);
        checkOutput("incr_key3_data", data_out, INCR_FF_EXP);
        applyStimulus(0, CTRL_INCR, 4'd5, 8'h00);
        applyStimulus(0, CTRL_NONE, 4'd5, 8'h00);
        checkOutput("incr_absent_valid", valid, 1'b0);

        applyStimulus(0, CTRL_CLR, 4'd1, 8'h00);
        applyStimulus(0, CTRL_NONE, 4'd1, 8'h00);
        checkOutput("clr_key1_valid", valid, 1'b0);
        applyStimulus(0, CTRL_LOAD, 4'd9, 8'h55);
        applyStimulus(0, CTRL_NONE, 4'd9, 8'h00);
        checkOutput("key9_data", data_out, 8'h55);

        // Dump with a second start pulse and an INCR on slot 2 while it is shown.
        applyStimulus(1, CTRL_NONE, 4'd0, 8'h00);
        for (int c = 1; c <= 17; c++) begin
            st  = (c == 6);
            cmd = (c == 10) ? CTRL_INCR : CTRL_NONE;
            k   = (c == 10) ? 4'd2 : ((c == 17) ? 4'd8 : 4'd0);
            applyStimulus(st, cmd, k, 8'h00);
            if (c == 1)  checkOutput("dump_slot0_data", data_out, 8'hDB);
            if (c == 5)  checkOutput("dump_slot1_data", data_out, 8'h55);
            if (c == 9)  checkOutput("dump_slot2_data", data_out, 8'hF0);
            if (c == 11) checkOutput("dump_slot2_live_incr", data_out, 8'hF1);
            if (c == 13) checkOutput("dump_slot3_data", data_out, INCR_FF_EXP);
            if (c == 16) checkOutput("dump_slot3_valid", valid, 1'b1);
            if (c == 17) checkOutput("post_dump_lookup_data", data_out, 8'hDB);
        end

        applyStimulus(0, CTRL_LOAD, 4'd10, 8'h77);
        applyStimulus(0, CTRL_NONE, 4'd9, 8'h00);
        checkOutput("replaced_key9_valid", valid, 1'b0);
        applyStimulus(0, CTRL_NONE, 4'd2, 8'h00);
        checkOutput("kept_key2_data", data_out, 8'hF1);
        applyStimulus(0, CTRL_NONE, 4'd10, 8'h00);
        checkOutput("key10_data", data_out, 8'h77);

        // Reset asserted in the middle of a dump.
        applyStimulus(1, CTRL_NONE, 4'd0, 8'h00);
        repeat (3) applyStimulus(0, CTRL_NONE, 4'd0, 8'h00);
        checkOutput("pre_reset_dump_data", data_out, 8'hDB);
        #1;
        compareEn   = 1'b0;
        async_reset = 1'b1;
        #1;
        checkOutput("midreset_data_out", data_out, 8'h00);
        checkOutput("midreset_valid", valid, 1'b0);
        modelReset();
        @(posedge clk);
        #1;
        async_reset = 1'b0;
        compareEn   = 1'b1;
        applyStimulus(0, CTRL_NONE, 4'd8, 8'h00);
        checkOutput("after_reset_key8_valid", valid, 1'b0);
        applyStimulus(0, CTRL_LOAD, 4'd6, 8'h12);
        applyStimulus(0, CTRL_NONE, 4'd6, 8'h00);
        checkOutput("after_reset_key6_data", data_out, 8'h12);

        @(negedge clk);
        compareEn = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
